// File: rtl/core_seq_ctrl_if.sv
// Instruction-memory handshake bundle for core_seq_ctrl.
// master: the sequencer (issues requests), slave: the instruction memory.
interface core_seq_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle FETCH -> DECODE -> EXEC -> WB sequencer for the RV32E core.
// Owns pc/ir, drives the imem handshake, selects ALU operands, produces the
// register-file write and the next pc. A misaligned jump/taken-branch target
// or an imem timeout or an illegal decode parks the FSM in FAULT until reset.
// Optional macro CORE_SEQ_PERF_EN adds cycle/instret counters; when undefined
// the counter ports are tied to zero.
module core_seq_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned IMEM_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   core_seq_ctrl_if.master        imem,
   output logic [31:0]            ir,
   input  logic [4:0]             op_sel,
   input  logic                   dec_illegal,
   input  logic [31:0]            imm,
   output logic                   alu_src_a_pc,
   output logic                   alu_src_b_imm,
   input  logic [31:0]            alu_result,
   input  logic                   branch_taken,
   input  logic                   stall,
   output logic                   rf_we,
   output logic [31:0]            rf_wdata,
   output logic [31:0]            pc,
   output logic                   retire,
   output logic                   halt,
   output logic [2:0]             state,
   output logic [31:0]            cycle_cnt,
   output logic [31:0]            instret_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [7:0] TMAX = 8'(IMEM_TIMEOUT - 1);

   state_t      st;
   logic [7:0]  tcnt;
   logic        req_q;
   logic [31:0] npc_q;

   logic        is_br;
   logic        jump_c;
   logic        mis_c;
   logic [31:0] pc_plus4;
   logic [31:0] npc_c;
   logic [31:0] wdata_c;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc;
   assign state          = st;

   // Next-pc, write data and misalignment check for the instruction in EXEC.
   always_comb begin
      is_br    = (op_sel >= 5'd17) && (op_sel <= 5'd20);
      pc_plus4 = pc + 32'd4;
      npc_c    = pc_plus4;
      jump_c   = 1'b0;
      wdata_c  = alu_result;
      if (is_br && branch_taken) begin
         npc_c  = pc + imm;
         jump_c = 1'b1;
      end
      if (op_sel == 5'd23) begin
         npc_c   = pc + imm;
         jump_c  = 1'b1;
         wdata_c = pc_plus4;
      end
      if (op_sel == 5'd24) begin
         npc_c   = {alu_result[31:1], 1'b0};
         jump_c  = 1'b1;
         wdata_c = pc_plus4;
      end
      if (op_sel == 5'd21) begin
         wdata_c = imm;
      end
      mis_c = jump_c & npc_c[1];
   end

   // Sequencer FSM with registered handshake, writeback and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= S_FETCH;
         pc            <= RESET_PC;
         ir            <= '0;
         tcnt          <= '0;
         req_q         <= 1'b0;
         npc_q         <= '0;
         alu_src_a_pc  <= 1'b0;
         alu_src_b_imm <= 1'b0;
         rf_we         <= 1'b0;
         rf_wdata      <= '0;
         retire        <= 1'b0;
         halt          <= 1'b0;
      end else begin
         rf_we  <= 1'b0;
         retire <= 1'b0;
         case (st)
            S_FETCH: begin
               if (imem.imem_ack) begin
                  ir    <= imem.imem_rdata;
                  tcnt  <= '0;
                  req_q <= 1'b0;
                  st    <= S_DECODE;
               end else if (tcnt == TMAX) begin
                  tcnt  <= '0;
                  req_q <= 1'b0;
                  halt  <= 1'b1;
                  st    <= S_FAULT;
               end else begin
                  tcnt  <= tcnt + 8'd1;
                  req_q <= 1'b1;
               end
            end
            S_DECODE: begin
               if (dec_illegal || (op_sel > 5'd24)) begin
                  halt <= 1'b1;
                  st   <= S_FAULT;
               end else begin
                  alu_src_b_imm <= ((op_sel >= 5'd9) && (op_sel <= 5'd16)) || (op_sel == 5'd22);
                  alu_src_a_pc  <= (op_sel == 5'd22);
                  st            <= S_EXEC;
               end
            end
            S_EXEC: begin
               // A bad target faults straight from EXEC so WB never shows a write.
               if (!stall) begin
                  if (mis_c) begin
                     halt <= 1'b1;
                     st   <= S_FAULT;
                  end else begin
                     npc_q    <= npc_c;
                     rf_we    <= ~is_br;
                     rf_wdata <= wdata_c;
                     retire   <= 1'b1;
                     st       <= S_WB;
                  end
               end
            end
            S_WB: begin
               pc    <= npc_q;
               req_q <= 1'b1;
               st    <= S_FETCH;
            end
            S_FAULT: begin
               halt  <= 1'b1;
               req_q <= 1'b0;
            end
            default: begin
               halt  <= 1'b1;
               req_q <= 1'b0;
               st    <= S_FAULT;
            end
         endcase
      end
   end

`ifdef CORE_SEQ_PERF_EN
   // Free-running cycle and retired-instruction counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (st != S_FAULT) cycle_cnt <= cycle_cnt + 32'd1;
         if (retire) instret_cnt <= instret_cnt + 32'd1;
      end
   end
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed self-checking bench for core_seq_ctrl (default parameters).
module tb_core_seq_ctrl;
   logic        clk;
   logic        rst_n;
   logic [31:0] ir;
   logic [4:0]  op_sel;
   logic        dec_illegal;
   logic [31:0] imm;
   logic        alu_src_a_pc;
   logic        alu_src_b_imm;
   logic [31:0] alu_result;
   logic        branch_taken;
   logic        stall;
   logic        rf_we;
   logic [31:0] rf_wdata;
   logic [31:0] pc;
   logic        retire;
   logic        halt;
   logic [2:0]  state;
   logic [31:0] cycle_cnt;
   logic [31:0] instret_cnt;

   int unsigned vectors;
   int unsigned miscompares;

   core_seq_ctrl_if bus ();

   core_seq_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (bus),
      .ir           (ir),
      .op_sel       (op_sel),
      .dec_illegal  (dec_illegal),
      .imm          (imm),
      .alu_src_a_pc (alu_src_a_pc),
      .alu_src_b_imm(alu_src_b_imm),
      .alu_result   (alu_result),
      .branch_taken (branch_taken),
      .stall        (stall),
      .rf_we        (rf_we),
      .rf_wdata     (rf_wdata),
      .pc           (pc),
      .retire       (retire),
      .halt         (halt),
      .state        (state),
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hands one instruction to the sequencer and leaves it in EXEC.
   task automatic issue(input logic [31:0] instr, input logic [4:0] op, input logic [31:0] im,
                        input logic [31:0] alu, input logic bt);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = instr;
      tick();
      chk("decode_state", 32'(state), 32'd1);
      chk("decode_ir", ir, instr);
      bus.imem_ack = 1'b0;
      op_sel       = op;
      imm          = im;
      alu_result   = alu;
      branch_taken = bt;
      tick();
      chk("exec_state", 32'(state), 32'd2);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_pc", pc, 32'h0);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      dec_illegal = 1'b0;
      op_sel      = 5'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst_n          = 1'b0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      op_sel         = '0;
      dec_illegal    = 1'b0;
      imm            = '0;
      alu_result     = '0;
      branch_taken   = 1'b0;
      stall          = 1'b0;
      #2;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_pc", pc, 32'h0);
      chk("reset_ir", ir, 32'h0);
      chk("reset_req", 32'(bus.imem_req), 32'd0);
      chk("reset_rf_we", 32'(rf_we), 32'd0);
      chk("reset_retire", 32'(retire), 32'd0);
      chk("reset_halt", 32'(halt), 32'd0);
      chk("reset_cycle_cnt", cycle_cnt, 32'h0);
      chk("reset_instret_cnt", instret_cnt, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // First post-reset clock raises the fetch request.
      tick();
      chk("fetch_state", 32'(state), 32'd0);
      chk("fetch_req", 32'(bus.imem_req), 32'd1);
      chk("fetch_addr", bus.imem_addr, 32'h0);

      // ADDI x1,x0,5
      issue(32'h0050_0093, 5'd9, 32'd5, 32'd5, 1'b0);
      chk("addi_src_b", 32'(alu_src_b_imm), 32'd1);
      chk("addi_src_a", 32'(alu_src_a_pc), 32'd0);
      tick();
      chk("addi_wb_state", 32'(state), 32'd3);
      chk("addi_rf_we", 32'(rf_we), 32'd1);
      chk("addi_wdata", rf_wdata, 32'd5);
      chk("addi_retire", 32'(retire), 32'd1);
      chk("addi_wb_pc", pc, 32'h0);
      tick();
      chk("addi_next_state", 32'(state), 32'd0);
      chk("addi_pc", pc, 32'h4);
      chk("addi_retire_low", 32'(retire), 32'd0);
      chk("addi_rf_we_low", 32'(rf_we), 32'd0);
      chk("addi_req", 32'(bus.imem_req), 32'd1);
      chk("addi_addr", bus.imem_addr, 32'h4);
`ifdef CORE_SEQ_PERF_EN
      chk("perf_instret", instret_cnt, 32'd1);
      chk("perf_cycle", cycle_cnt, 32'd5);
`else
      chk("perf_instret_tied", instret_cnt, 32'd0);
      chk("perf_cycle_tied", cycle_cnt, 32'd0);
`endif

      // JAL +12 from 0x4 -> 0x10
      issue(32'h00C0_00EF, 5'd23, 32'd12, 32'd0, 1'b0);
      tick();
      chk("jal1_wdata", rf_wdata, 32'h8);
      chk("jal1_rf_we", 32'(rf_we), 32'd1);
      tick();
      chk("jal1_pc", pc, 32'h10);

      // BEQ taken, imm +8 at 0x10
      issue(32'h0000_0463, 5'd17, 32'd8, 32'd0, 1'b1);
      chk("beq_src_b", 32'(alu_src_b_imm), 32'd0);
      tick();
      chk("beq_t_rf_we", 32'(rf_we), 32'd0);
      chk("beq_t_retire", 32'(retire), 32'd1);
      tick();
      chk("beq_t_pc", pc, 32'h18);

      // JAL -8 from 0x18 -> 0x10 (wrapping add)
      issue(32'hFF9F_F0EF, 5'd23, 32'hFFFF_FFF8, 32'd0, 1'b0);
      tick();
      tick();
      chk("jal_neg_pc", pc, 32'h10);

      // BEQ not taken at 0x10
      issue(32'h0000_0463, 5'd17, 32'd8, 32'd0, 1'b0);
      tick();
      chk("beq_nt_rf_we", 32'(rf_we), 32'd0);
      tick();
      chk("beq_nt_pc", pc, 32'h14);

      // JAL +12 from 0x14 -> 0x20
      issue(32'h00C0_00EF, 5'd23, 32'd12, 32'd0, 1'b0);
      tick();
      tick();
      chk("jal2_pc", pc, 32'h20);

      // JAL 0x100 at 0x20
      issue(32'h1000_00EF, 5'd23, 32'h100, 32'd0, 1'b0);
      tick();
      chk("jal3_wdata", rf_wdata, 32'h24);
      tick();
      chk("jal3_pc", pc, 32'h120);

      // JALR with alu_result 0x205 -> target 0x204
      issue(32'h0000_80E7, 5'd24, 32'd0, 32'h205, 1'b0);
      tick();
      chk("jalr_wdata", rf_wdata, 32'h124);
      chk("jalr_rf_we", 32'(rf_we), 32'd1);
      tick();
      chk("jalr_pc", pc, 32'h204);

      // LUI writes the immediate
      issue(32'h1234_50B7, 5'd21, 32'h1234_5000, 32'h0000_DEAD, 1'b0);
      tick();
      chk("lui_wdata", rf_wdata, 32'h1234_5000);
      tick();
      chk("lui_pc", pc, 32'h208);

      // AUIPC with stall held for 3 cycles in EXEC
      issue(32'h0000_1097, 5'd22, 32'h1000, 32'h1208, 1'b0);
      chk("auipc_src_a", 32'(alu_src_a_pc), 32'd1);
      chk("auipc_src_b", 32'(alu_src_b_imm), 32'd1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_state", 32'(state), 32'd2);
         chk("stall_rf_we", 32'(rf_we), 32'd0);
      end
      chk("stall_src_a_held", 32'(alu_src_a_pc), 32'd1);
      stall = 1'b0;
      tick();
      chk("auipc_wb_state", 32'(state), 32'd3);
      chk("auipc_wdata", rf_wdata, 32'h1208);
      tick();
      chk("auipc_pc", pc, 32'h20C);

      // JAL to misaligned 0x22 from 0x20C
      issue(32'hE17F_F0EF, 5'd23, 32'hFFFF_FE16, 32'd0, 1'b0);
      tick();
      chk("mis_state", 32'(state), 32'd7);
      chk("mis_halt", 32'(halt), 32'd1);
      chk("mis_rf_we", 32'(rf_we), 32'd0);
      chk("mis_retire", 32'(retire), 32'd0);
      chk("mis_pc", pc, 32'h20C);
      chk("mis_req", 32'(bus.imem_req), 32'd0);
      tick();
      tick();
      chk("fault_sticky", 32'(state), 32'd7);
      chk("fault_halt_sticky", 32'(halt), 32'd1);

      // imem never acks: FAULT after 16 FETCH cycles
      do_reset();
      repeat (15) tick();
      chk("tmo_state_15", 32'(state), 32'd0);
      chk("tmo_req_15", 32'(bus.imem_req), 32'd1);
      tick();
      chk("tmo_state_16", 32'(state), 32'd7);
      chk("tmo_halt", 32'(halt), 32'd1);
      chk("tmo_req_drop", 32'(bus.imem_req), 32'd0);

      // Ack in the last allowed cycle wins over the timeout, then op_sel 25 faults
      do_reset();
      repeat (15) tick();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hCAFE_0013;
      tick();
      bus.imem_ack = 1'b0;
      chk("ack_wins_state", 32'(state), 32'd1);
      chk("ack_wins_ir", ir, 32'hCAFE_0013);
      op_sel = 5'd25;
      tick();
      chk("opsel25_state", 32'(state), 32'd7);
      chk("opsel25_halt", 32'(halt), 32'd1);

      // dec_illegal faults from DECODE
      do_reset();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hFFFF_FFFF;
      tick();
      bus.imem_ack = 1'b0;
      op_sel       = 5'd9;
      dec_illegal  = 1'b1;
      tick();
      chk("illegal_state", 32'(state), 32'd7);
      chk("illegal_halt", 32'(halt), 32'd1);
      dec_illegal = 1'b0;

      // Reset while in EXEC aborts the instruction with no write
      do_reset();
      issue(32'h0050_0093, 5'd9, 32'd5, 32'd5, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_rf_we", 32'(rf_we), 32'd0);
      chk("abort_ir", ir, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("abort_pc", pc, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
